// File: rtl/procyon_lsu_victim_buffer_pkg.sv
// Shared helpers for the LSU victim buffer slice.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
package procyon_lsu_victim_buffer_pkg;

    // Pointer width for a power-of-2 circular queue: index bits plus one wrap
    // bit, so that full and empty can be told apart when the indices are equal.
    function automatic int vb_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/procyon_ff.sv
// Plain enabled register with no reset, used for payload storage.
// Latency: 1 cycle from i_d to o_q when i_en is high.
// Backpressure: none; holds its value while i_en is low.
// Ports: clk, i_en (load enable), i_d (next value), o_q (registered value).
module procyon_ff #(
    parameter int OPTN_DATA_WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       i_en,
    input  logic [OPTN_DATA_WIDTH-1:0] i_d,
    output logic [OPTN_DATA_WIDTH-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (i_en) o_q <= i_d;
    end

endmodule

// File: rtl/procyon_lsu_vb_match.sv
// Per-entry line-address comparator for the victim buffer lookup.
// Latency: combinational.
// Backpressure: none.
// Ports: i_vb_valid (entry valid bits), i_vb_addr (entry line addresses),
//        i_lookup_addr (address to check), o_hit_vec (one hit bit per entry).
module procyon_lsu_vb_match #(
    parameter int OPTN_ADDR_WIDTH   = 32,
    parameter int OPTN_DC_LINE_SIZE = 32,
    parameter int OPTN_VB_DEPTH     = 4
) (
    input  logic [OPTN_VB_DEPTH-1:0]                      i_vb_valid,
    input  logic [OPTN_VB_DEPTH-1:0][OPTN_ADDR_WIDTH-1:0] i_vb_addr,
    input  logic [OPTN_ADDR_WIDTH-1:0]                    i_lookup_addr,
    output logic [OPTN_VB_DEPTH-1:0]                      o_hit_vec
);

    // Offset bits are masked out so any byte address within a line matches.
    localparam logic [OPTN_ADDR_WIDTH-1:0] LINE_MASK =
        ~(OPTN_ADDR_WIDTH'(OPTN_DC_LINE_SIZE - 1));

    always_comb begin
        o_hit_vec = '0;
        for (int i = 0; i < OPTN_VB_DEPTH; i++) begin
            o_hit_vec[i] = i_vb_valid[i] &
                           (((i_vb_addr[i] ^ i_lookup_addr) & LINE_MASK) == '0);
        end
    end

endmodule

// File: rtl/procyon_srff.sv
// Enabled register with synchronous active-low reset to a supplied value.
// Latency: 1 cycle from i_set to o_q when i_en is high.
// Backpressure: none; holds its value while i_en is low.
// Ports: clk, n_rst (sync, active-low), i_en, i_set (next value), i_reset (reset value), o_q.
module procyon_srff #(
    parameter int OPTN_DATA_WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       i_en,
    input  logic [OPTN_DATA_WIDTH-1:0] i_set,
    input  logic [OPTN_DATA_WIDTH-1:0] i_reset,
    output logic [OPTN_DATA_WIDTH-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (!n_rst)    o_q <= i_reset;
        else if (i_en) o_q <= i_set;
    end

endmodule

// File: rtl/procyon_lsu_victim_buffer.sv
// In-order queue of dirty victim lines awaiting writeback, with address lookup.
// Latency: enqueue visible on o_wb_* the next cycle; lookup hit is combinational (bypass).
// Backpressure: o_full raised one slot early (count >= DEPTH-1); head held until i_wb_ack.
// Ports: clk, n_rst (sync, active-low); i_victim_en/addr/data enqueue side;
//        o_full/o_empty status; i_lookup_addr/o_lookup_hit match port;
//        o_wb_req/addr/data/i_wb_ack writeback side.
module procyon_lsu_victim_buffer
    import procyon_lsu_victim_buffer_pkg::*;
#(
    parameter int OPTN_ADDR_WIDTH   = 32,
    parameter int OPTN_DC_LINE_SIZE = 32,
    parameter int OPTN_VB_DEPTH     = 4,
    parameter int DC_LINE_WIDTH     = OPTN_DC_LINE_SIZE * 8
) (
    input  logic                       clk,
    input  logic                       n_rst,

    input  logic                       i_victim_en,
    input  logic [OPTN_ADDR_WIDTH-1:0] i_victim_addr,
    input  logic [DC_LINE_WIDTH-1:0]   i_victim_data,
    output logic                       o_full,
    output logic                       o_empty,

    input  logic [OPTN_ADDR_WIDTH-1:0] i_lookup_addr,
    output logic                       o_lookup_hit,

    output logic                       o_wb_req,
    output logic [OPTN_ADDR_WIDTH-1:0] o_wb_addr,
    output logic [DC_LINE_WIDTH-1:0]   o_wb_data,
    input  logic                       i_wb_ack
);

    localparam int PTR_W = vb_ptr_width(OPTN_VB_DEPTH);
    localparam int IDX_W = PTR_W - 1;
    localparam logic [OPTN_ADDR_WIDTH-1:0] LINE_MASK =
        ~(OPTN_ADDR_WIDTH'(OPTN_DC_LINE_SIZE - 1));

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] count;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             enq;
    logic             deq;

    logic [OPTN_VB_DEPTH-1:0]                      vb_valid;
    logic [OPTN_VB_DEPTH-1:0][OPTN_ADDR_WIDTH-1:0] vb_addr;
    logic [OPTN_VB_DEPTH-1:0][DC_LINE_WIDTH-1:0]   vb_data;
    logic [OPTN_VB_DEPTH-1:0]                      hit_vec;
    logic                                          bypass_hit;

    // Modulo-2*DEPTH difference; the wrap bit disambiguates full from empty.
    assign count    = tail - head;
    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];

    // An enqueue into a completely full queue would overwrite the head that
    // is being written back, so it is dropped rather than corrupting state.
    assign enq = i_victim_en & (count != PTR_W'(OPTN_VB_DEPTH));
    assign deq = ~o_empty & i_wb_ack;

    assign o_empty  = (count == '0);
    assign o_full   = (count >= PTR_W'(OPTN_VB_DEPTH - 1));
    assign o_wb_req = ~o_empty;

    procyon_srff #(.OPTN_DATA_WIDTH(PTR_W)) head_srff (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_en   (deq),
        .i_set  (head + 1'b1),
        .i_reset('0),
        .o_q    (head)
    );

    procyon_srff #(.OPTN_DATA_WIDTH(PTR_W)) tail_srff (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_en   (enq),
        .i_set  (tail + 1'b1),
        .i_reset('0),
        .o_q    (tail)
    );

    genvar gi;
    generate
        for (gi = 0; gi < OPTN_VB_DEPTH; gi++) begin : gen_entry
            logic entry_we;
            logic entry_rd;

            // Write and release never target the same entry in one cycle: that
            // would need head_idx == tail_idx with the queue non-empty, i.e.
            // full, where the enqueue is already suppressed.
            assign entry_we = enq & (tail_idx == IDX_W'(gi));
            assign entry_rd = deq & (head_idx == IDX_W'(gi));

            procyon_srff #(.OPTN_DATA_WIDTH(1)) valid_srff (
                .clk    (clk),
                .n_rst  (n_rst),
                .i_en   (entry_we | entry_rd),
                .i_set  (entry_we),
                .i_reset(1'b0),
                .o_q    (vb_valid[gi])
            );

            procyon_ff #(.OPTN_DATA_WIDTH(OPTN_ADDR_WIDTH)) addr_ff (
                .clk (clk),
                .i_en(entry_we),
                .i_d (i_victim_addr & LINE_MASK),
                .o_q (vb_addr[gi])
            );

            procyon_ff #(.OPTN_DATA_WIDTH(DC_LINE_WIDTH)) data_ff (
                .clk (clk),
                .i_en(entry_we),
                .i_d (i_victim_data),
                .o_q (vb_data[gi])
            );
        end
    endgenerate

    procyon_lsu_vb_match #(
        .OPTN_ADDR_WIDTH  (OPTN_ADDR_WIDTH),
        .OPTN_DC_LINE_SIZE(OPTN_DC_LINE_SIZE),
        .OPTN_VB_DEPTH    (OPTN_VB_DEPTH)
    ) vb_match (
        .i_vb_valid   (vb_valid),
        .i_vb_addr    (vb_addr),
        .i_lookup_addr(i_lookup_addr),
        .o_hit_vec    (hit_vec)
    );

    // A victim arriving this cycle is not yet in storage, but the miss path
    // must already see it so it does not fetch a stale copy from memory.
    assign bypass_hit   = i_victim_en &
                          (((i_victim_addr ^ i_lookup_addr) & LINE_MASK) == '0);
    assign o_lookup_hit = (|hit_vec) | bypass_hit;

    // Head entry cannot be overwritten while unacked, so these stay stable.
    assign o_wb_addr = vb_addr[head_idx];
    assign o_wb_data = vb_data[head_idx];

endmodule

// File: tb/tb_procyon_lsu_victim_buffer.sv
// Directed bench for the victim buffer: reset, ordering, full slack, bypass, wrap.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns later.
// Backpressure: a bench-side occupancy count guards against illegal enqueues.
module tb_procyon_lsu_victim_buffer;

    localparam int AW = 32;
    localparam int LS = 32;
    localparam int DP = 4;
    localparam int DW = LS * 8;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          victim_en;
    logic [AW-1:0] victim_addr;
    logic [DW-1:0] victim_data;
    logic          full;
    logic          empty;
    logic [AW-1:0] lookup_addr;
    logic          lookup_hit;
    logic          wb_req;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_ack;

    int n_vec = 0;
    int n_err = 0;
    int occ   = 0;

    always #5 clk = ~clk;

    procyon_lsu_victim_buffer #(
        .OPTN_ADDR_WIDTH  (AW),
        .OPTN_DC_LINE_SIZE(LS),
        .OPTN_VB_DEPTH    (DP)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .i_victim_en  (victim_en),
        .i_victim_addr(victim_addr),
        .i_victim_data(victim_data),
        .o_full       (full),
        .o_empty      (empty),
        .i_lookup_addr(lookup_addr),
        .o_lookup_hit (lookup_hit),
        .o_wb_req     (wb_req),
        .o_wb_addr    (wb_addr),
        .o_wb_data    (wb_data),
        .i_wb_ack     (wb_ack)
    );

    // Independent occupancy count; enqueueing into a full queue is illegal.
    always @(posedge clk) begin
        if (!n_rst) begin
            occ <= 0;
        end else begin
            assert (!(victim_en && occ == DP))
                else $error("enqueue while buffer holds %0d entries", occ);
            occ <= occ + (victim_en ? 1 : 0) - ((wb_ack && occ != 0) ? 1 : 0);
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input int k);
        return {8{32'hD000_0000 + 32'(k)}};
    endfunction

    logic [AW-1:0] la [0:3];

    initial begin
        n_rst       = 1'b0;
        victim_en   = 1'b0;
        victim_addr = '0;
        victim_data = '0;
        lookup_addr = '0;
        wb_ack      = 1'b0;
        cyc();
        cyc();
        n_rst = 1'b1;

        // Idle after reset, ack toggling must be ignored.
        for (int i = 0; i < 10; i++) begin
            wb_ack = i[0];
            #1;
            chk("idle_empty", DW'(empty), DW'(1));
            chk("idle_req",   DW'(wb_req), DW'(0));
            chk("idle_full",  DW'(full), DW'(0));
            chk("idle_hit",   DW'(lookup_hit), DW'(0));
            cyc();
        end
        wb_ack = 1'b0;

        // Single enqueue: offset bits stripped, data passed through, ack drains.
        victim_en   = 1'b1;
        victim_addr = 32'h1000_0047;
        victim_data = pat(100);
        cyc();
        victim_en = 1'b0;
        #1;
        chk("one_req",   DW'(wb_req), DW'(1));
        chk("one_empty", DW'(empty), DW'(0));
        chk("one_addr",  DW'(wb_addr), DW'(32'h1000_0040));
        chk("one_data",  wb_data, pat(100));
        wb_ack = 1'b1;
        cyc();
        wb_ack = 1'b0;
        #1;
        chk("one_drained", DW'(empty), DW'(1));
        chk("one_req_off", DW'(wb_req), DW'(0));

        // Fill to full slack, take the fourth anyway, then drain in order.
        la[0] = 32'h3000_0000; la[1] = 32'h3000_0020;
        la[2] = 32'h3000_0040; la[3] = 32'h3000_0060;
        for (int k = 0; k < 4; k++) begin
            victim_en   = 1'b1;
            victim_addr = la[k] | 32'h1F;
            victim_data = pat(k);
            #1;
            chk("fill_full", DW'(full), DW'(k == 3));
            cyc();
        end
        victim_en = 1'b0;
        wb_ack    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_full", DW'(full), DW'(k <= 1));
            chk("drain_addr", DW'(wb_addr), DW'(la[k]));
            chk("drain_data", wb_data, pat(k));
            cyc();
        end
        wb_ack = 1'b0;
        #1;
        chk("drain_empty", DW'(empty), DW'(1));
        chk("drain_full0", DW'(full), DW'(0));

        // Lookup bypass of an incoming victim, then storage hit until acked.
        victim_en   = 1'b1;
        victim_addr = 32'h2000_0000;
        victim_data = pat(200);
        lookup_addr = 32'h2000_0010;
        #1;
        chk("byp_hit", DW'(lookup_hit), DW'(1));
        cyc();
        victim_en = 1'b0;
        #1;
        chk("stor_hit", DW'(lookup_hit), DW'(1));
        lookup_addr = 32'h2000_0020;
        #1;
        chk("stor_miss", DW'(lookup_hit), DW'(0));
        lookup_addr = 32'h2000_001F;
        wb_ack      = 1'b1;
        #1;
        chk("hit_under_ack", DW'(lookup_hit), DW'(1));
        cyc();
        wb_ack = 1'b0;
        #1;
        chk("hit_after_ack", DW'(lookup_hit), DW'(0));

        // Hold three entries, then enqueue and ack together across a wrap.
        for (int k = 0; k < 3; k++) begin
            victim_en   = 1'b1;
            victim_addr = 32'h4000_0000 + 32'(k * 32) + 32'h3;
            victim_data = pat(300 + k);
            cyc();
        end
        for (int k = 0; k < 8; k++) begin
            victim_en   = 1'b1;
            victim_addr = 32'h4000_0000 + 32'((k + 3) * 32) + 32'h3;
            victim_data = pat(303 + k);
            wb_ack      = 1'b1;
            #1;
            chk("ss_addr", DW'(wb_addr), DW'(32'h4000_0000 + 32'(k * 32)));
            chk("ss_data", wb_data, pat(300 + k));
            chk("ss_full", DW'(full), DW'(1));
            cyc();
        end
        victim_en = 1'b0;
        for (int k = 8; k < 11; k++) begin
            #1;
            chk("ss_tail_addr", DW'(wb_addr), DW'(32'h4000_0000 + 32'(k * 32)));
            chk("ss_tail_data", wb_data, pat(300 + k));
            cyc();
        end
        wb_ack = 1'b0;
        #1;
        chk("ss_empty", DW'(empty), DW'(1));

        // Reset while a writeback is pending with two entries queued.
        for (int k = 0; k < 2; k++) begin
            victim_en   = 1'b1;
            victim_addr = 32'h6000_0000 + 32'(k * 32);
            victim_data = pat(600 + k);
            cyc();
        end
        victim_en   = 1'b0;
        lookup_addr = 32'h6000_0000;
        #1;
        chk("pre_rst_hit", DW'(lookup_hit), DW'(1));
        chk("pre_rst_req", DW'(wb_req), DW'(1));
        wb_ack = 1'b1;
        n_rst  = 1'b0;
        cyc();
        n_rst  = 1'b1;
        wb_ack = 1'b0;
        #1;
        chk("rst_empty", DW'(empty), DW'(1));
        chk("rst_req",   DW'(wb_req), DW'(0));
        chk("rst_hit",   DW'(lookup_hit), DW'(0));
        chk("rst_full",  DW'(full), DW'(0));

        // Queue works normally after the mid-flight reset.
        victim_en   = 1'b1;
        victim_addr = 32'h7000_0005;
        victim_data = pat(700);
        cyc();
        victim_en = 1'b0;
        #1;
        chk("post_rst_addr", DW'(wb_addr), DW'(32'h7000_0000));
        chk("post_rst_data", wb_data, pat(700));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
